multi_audio_wave: RTL and testbench

Multi-channel, time-multiplexed audio waveform generator and mixer; parametrised successor to the single-frequency audio level block. Each channel holds its own phase accumulator, phase increment and waveform select, written through a one-cycle config port. Once per sample period a sequencer walks all channels, advances their phases and sums their levels into one unsigned mixed sample for the PWM/DAC stage.

---
 rtl/multi_audio_wave.sv | 164 ++++++++++++++++
 tb/tb_multi_audio_wave.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_audio_wave.sv
// Time-multiplexed multi-channel waveform generator and mixer (SIN/TRI/SQ/SAW/OFF per channel).
// Define MULTI_AUDIO_WAVE_SINE_EN to build the quarter-wave sine table; otherwise SIN sits at midscale.
module multi_audio_wave #(
   parameter int BITS      = 6,
   parameter int CHANNELS  = 4,
   parameter int PHASE_W   = 16,
   parameter int DIV       = 64,
   localparam int CH_W     = $clog2(CHANNELS),
   localparam int OUT_W    = BITS + CH_W
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               cfg_we,
   input  logic [CH_W-1:0]    cfg_ch,
   input  logic [2:0]         cfg_form,
   input  logic [PHASE_W-1:0] cfg_inc,
   input  logic               cfg_phase_clr,
   output logic [OUT_W-1:0]   sample,
   output logic               sample_valid,
   output logic               busy
);
   localparam int CNT_W = $clog2(DIV);
   localparam logic [BITS-1:0] MID = {1'b1, {(BITS-1){1'b0}}};
   localparam logic [2:0] F_SIN = 3'd0, F_TRI = 3'd1, F_SQ = 3'd2, F_SAW = 3'd3, F_OFF = 3'd4;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [CH_W-1:0]    ch_q, ch_d;
   logic [OUT_W-1:0]   sum_q, sum_d, sample_q, sample_d;
   logic [PHASE_W-1:0] phase_q [CHANNELS];
   logic [PHASE_W-1:0] phase_d [CHANNELS];
   logic [PHASE_W-1:0] inc_q   [CHANNELS];
   logic [PHASE_W-1:0] inc_d   [CHANNELS];
   logic [2:0]         form_q  [CHANNELS];
   logic [2:0]         form_d  [CHANNELS];
   logic               tick, last_ch, cur_msb;
   logic [BITS-1:0]    cur_top, cur_tri, level;
   logic [2:0]         cur_form;

`ifdef MULTI_AUDIO_WAVE_SINE_EN
   logic [7:0] cur_sin_idx;

   // Q[k] = round(31*sin(pi/2*(k+0.5)/64)); amplitude tabulated for BITS=6.
   function automatic logic [4:0] quarter_sin(input logic [5:0] k);
      logic [4:0] q;
      case (k)
         6'd0:  q = 5'd0;  6'd1:  q = 5'd1;  6'd2:  q = 5'd2;  6'd3:  q = 5'd3;  6'd4:  q = 5'd3;  6'd5:  q = 5'd4;  6'd6:  q = 5'd5;  6'd7:  q = 5'd6;
         6'd8:  q = 5'd6;  6'd9:  q = 5'd7;  6'd10: q = 5'd8;  6'd11: q = 5'd9;  6'd12: q = 5'd9;  6'd13: q = 5'd10; 6'd14: q = 5'd11; 6'd15: q = 5'd12;
         6'd16: q = 5'd12; 6'd17: q = 5'd13; 6'd18: q = 5'd14; 6'd19: q = 5'd14; 6'd20: q = 5'd15; 6'd21: q = 5'd16; 6'd22: q = 5'd16; 6'd23: q = 5'd17;
         6'd24: q = 5'd18; 6'd25: q = 5'd18; 6'd26: q = 5'd19; 6'd27: q = 5'd19; 6'd28: q = 5'd20; 6'd29: q = 5'd21; 6'd30: q = 5'd21; 6'd31: q = 5'd22;
         6'd32: q = 5'd22; 6'd33: q = 5'd23; 6'd34: q = 5'd23; 6'd35: q = 5'd24; 6'd36: q = 5'd24; 6'd37: q = 5'd25; 6'd38: q = 5'd25; 6'd39: q = 5'd26;
         6'd40: q = 5'd26; 6'd41: q = 5'd26; 6'd42: q = 5'd27; 6'd43: q = 5'd27; 6'd44: q = 5'd28; 6'd45: q = 5'd28; 6'd46: q = 5'd28; 6'd47: q = 5'd28;
         6'd48: q = 5'd29; 6'd49: q = 5'd29; 6'd50: q = 5'd29; 6'd51: q = 5'd30; 6'd52: q = 5'd30; 6'd53: q = 5'd30; 6'd54: q = 5'd30; 6'd55: q = 5'd30;
         6'd56: q = 5'd30; 6'd57: q = 5'd31; 6'd58: q = 5'd31; 6'd59: q = 5'd31; 6'd60: q = 5'd31; 6'd61: q = 5'd31; 6'd62: q = 5'd31; default: q = 5'd31;
      endcase
      return q;
   endfunction

   // Odd quadrants walk the table backwards; the upper half mirrors below midscale.
   function automatic logic [BITS-1:0] sin_level(input logic [7:0] idx);
      logic [5:0] k;
      logic [BITS-1:0] q;
      k = idx[6] ? ~idx[5:0] : idx[5:0];
      q = BITS'(quarter_sin(k));
      return idx[7] ? MID - q : MID + q;
   endfunction
`endif

   assign tick    = (cnt_q == '0);
   assign last_ch = (ch_q == CH_W'(CHANNELS-1));

   always_ff @(posedge clock) begin
      if (!reset) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (tick) state_d = S_RUN;
         S_RUN:   if (last_ch) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      busy         = (state_q == S_RUN) || (state_q == S_DONE);
      sample_valid = (state_q == S_DONE);
   end

   // Level of the channel in the current RUN slot, from its pre-update phase and form.
   always_comb begin
      cur_msb  = phase_q[ch_q][PHASE_W-1];
      cur_top  = phase_q[ch_q][PHASE_W-1 -: BITS];
      cur_tri  = phase_q[ch_q][PHASE_W-2 -: BITS];
      cur_form = form_q[ch_q];
`ifdef MULTI_AUDIO_WAVE_SINE_EN
      cur_sin_idx = phase_q[ch_q][PHASE_W-1 -: 8];
`endif
      case (cur_form)
         F_SQ:    level = cur_msb ? '0 : '1;
         F_SAW:   level = cur_top;
         F_TRI:   level = cur_msb ? ~cur_tri : cur_tri;
`ifdef MULTI_AUDIO_WAVE_SINE_EN
         F_SIN:   level = sin_level(cur_sin_idx);
`endif
         default: level = MID;
      endcase
   end

   // A config clear lands after the RUN accumulate so it wins on a same-channel collision.
   always_comb begin
      cnt_d    = (cnt_q == CNT_W'(DIV-1)) ? '0 : cnt_q + 1'b1;
      ch_d     = ch_q;
      sum_d    = sum_q;
      sample_d = sample_q;
      phase_d  = phase_q;
      inc_d    = inc_q;
      form_d   = form_q;
      if ((state_q == S_IDLE) && tick) begin
         ch_d  = '0;
         sum_d = '0;
      end
      if (state_q == S_RUN) begin
         sum_d         = sum_q + OUT_W'(level);
         ch_d          = ch_q + 1'b1;
         phase_d[ch_q] = phase_q[ch_q] + inc_q[ch_q];
         if (last_ch) sample_d = sum_q + OUT_W'(level);
      end
      if (cfg_we) begin
         inc_d[cfg_ch]  = cfg_inc;
         form_d[cfg_ch] = cfg_form;
         if (cfg_phase_clr) phase_d[cfg_ch] = '0;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         cnt_q    <= '0;
         ch_q     <= '0;
         sum_q    <= '0;
         sample_q <= '0;
         for (int i = 0; i < CHANNELS; i++) begin
            phase_q[i] <= '0;
            inc_q[i]   <= '0;
            form_q[i]  <= F_OFF;
         end
      end else begin
         cnt_q    <= cnt_d;
         ch_q     <= ch_d;
         sum_q    <= sum_d;
         sample_q <= sample_d;
         phase_q  <= phase_d;
         inc_q    <= inc_d;
         form_q   <= form_d;
      end
   end

   assign sample = sample_q;

endmodule

// File: tb/tb_multi_audio_wave.sv
// Bench for multi_audio_wave: pass-level reference model, directed waveform cases, collisions, random config.
// Reset handshake: sample/valid/busy low while reset is held; first valid CHANNELS+1 cycles after release.
module tb_multi_audio_wave;
   localparam int BITS     = 6;
   localparam int CHANNELS = 4;
   localparam int PHASE_W  = 16;
   localparam int DIV      = 64;
   localparam int CH_W     = 2;
   localparam int OUT_W    = 8;
   localparam int MID      = 1 << (BITS-1);
   localparam int MAXL     = (1 << BITS) - 1;

   logic               clock = 1'b0;
   logic               reset = 1'b0;
   logic               cfg_we = 1'b0;
   logic [CH_W-1:0]    cfg_ch = '0;
   logic [2:0]         cfg_form = '0;
   logic [PHASE_W-1:0] cfg_inc = '0;
   logic               cfg_phase_clr = 1'b0;
   logic [OUT_W-1:0]   sample;
   logic               sample_valid;
   logic               busy;

   always #5 clock = ~clock;

   multi_audio_wave #(.BITS(BITS), .CHANNELS(CHANNELS), .PHASE_W(PHASE_W), .DIV(DIV)) dut (
      .clock(clock), .reset(reset), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_form(cfg_form),
      .cfg_inc(cfg_inc), .cfg_phase_clr(cfg_phase_clr), .sample(sample),
      .sample_valid(sample_valid), .busy(busy)
   );

   int n_vec  = 0;
   int n_miss = 0;
   int m_phase [CHANNELS];
   int m_inc   [CHANNELS];
   int m_form  [CHANNELS];
   logic [OUT_W-1:0] exp_q [$];

   task automatic check(input string tag, input int got, input int exp);
      n_vec++;
      if (got != exp) begin
         n_miss++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int sine_ref(input int p);
      int q, k, v;
      real a;
      q = p >> (PHASE_W-2);
      k = (p >> (PHASE_W-8)) % 64;
      if (q % 2 == 1) k = 63 - k;
      a = 3.14159265358979 / 2.0 * (real'(k) + 0.5) / 64.0;
      v = $rtoi(real'(MID - 1) * $sin(a) + 0.5);
      return (q < 2) ? MID + v : MID - v;
   endfunction

   function automatic int level_ref(input int form, input int p);
      int u;
      int half;
      half = 1 << (PHASE_W-1);
      u = (p >> (PHASE_W-1-BITS)) % (1 << BITS);
      case (form)
         1: return (p < half) ? u : MAXL - u;
         2: return (p < half) ? MAXL : 0;
         3: return p >> (PHASE_W-BITS);
`ifdef MULTI_AUDIO_WAVE_SINE_EN
         0: return sine_ref(p);
`endif
         default: return MID;
      endcase
   endfunction

   // One sample period: every channel contributes from its current phase, then advances.
   task automatic model_pass();
      int s;
      s = 0;
      for (int c = 0; c < CHANNELS; c++) begin
         s += level_ref(m_form[c], m_phase[c]);
         m_phase[c] = (m_phase[c] + m_inc[c]) % (1 << PHASE_W);
      end
      exp_q.push_back(OUT_W'(s));
   endtask

   task automatic model_write(input int c, input int f, input int inc, input bit clr);
      m_inc[c]  = inc;
      m_form[c] = f;
      if (clr) m_phase[c] = 0;
   endtask

   task automatic model_reset();
      for (int c = 0; c < CHANNELS; c++) begin
         m_phase[c] = 0;
         m_inc[c]   = 0;
         m_form[c]  = 4;
      end
      exp_q.delete();
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic drive_write(input int c, input int f, input int inc, input bit clr);
      cfg_we        = 1'b1;
      cfg_ch        = CH_W'(c);
      cfg_form      = 3'(f);
      cfg_inc       = PHASE_W'(inc);
      cfg_phase_clr = clr;
   endtask

   // Starts in a valid cycle V and ends in the next one, V+DIV. The optional write lands in cycle V+w;
   // channel c is processed at V+DIV-CHANNELS+c, so a write at or after that slot only shows next pass.
   task automatic run_period(input bit do_wr, input int w, input int c, input int f, input int inc, input bit clr);
      int busy_n, valid_n, valid_at;
      bit after;
      busy_n   = 0;
      valid_n  = 0;
      valid_at = 0;
      after    = do_wr && (w >= DIV - CHANNELS + c);
      if (do_wr && !after) model_write(c, f, inc, clr);
      for (int i = 1; i <= DIV; i++) begin
         step();
         cfg_we        = 1'b0;
         cfg_phase_clr = 1'b0;
         if (do_wr && i == w) drive_write(c, f, inc, clr);
         if (busy) busy_n++;
         if (sample_valid) begin
            valid_n++;
            valid_at = i;
         end
      end
      model_pass();
      if (after) model_write(c, f, inc, clr);
      check("valid_count", valid_n, 1);
      check("valid_pos", valid_at, DIV);
      check("busy_cycles", busy_n, CHANNELS + 1);
      check("sample", int'(sample), int'(exp_q.pop_front()));
   endtask

   // Holds reset, checks the reset state, releases and lands in the first valid cycle.
   task automatic apply_reset();
      int seen, n, busy_n;
      seen          = 0;
      n             = 0;
      busy_n        = 0;
      cfg_we        = 1'b0;
      cfg_phase_clr = 1'b0;
      reset         = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         if (sample_valid) seen++;
      end
      check("rst_valid", seen, 0);
      check("rst_sample", int'(sample), 0);
      check("rst_busy", int'(busy), 0);
      model_reset();
      reset = 1'b1;
      while (!sample_valid && n < 100) begin
         step();
         n++;
         if (busy) busy_n++;
      end
      check("first_latency", n, CHANNELS + 1);
      check("first_busy", busy_n, CHANNELS + 1);
      model_pass();
      check("first_sample", int'(sample), int'(exp_q.pop_front()));
   endtask

   int sq_exp [5] = '{159, 159, 96, 96, 159};
   int peak;

   initial begin
      apply_reset();
      check("idle_midscale", int'(sample), 128);
      for (int i = 0; i < 2; i++) run_period(0, 0, 0, 0, 0, 0);
      check("idle_midscale", int'(sample), 128);

      // Square on ch0, quarter-cycle increment.
      for (int i = 0; i < 5; i++) begin
         run_period(i == 0, 1, 0, 2, 'h4000, 0);
         check("sq_seq", int'(sample), sq_exp[i]);
      end

      // Sawtooth on ch1 ramps by one level per pass and wraps after 64.
      run_period(1, 1, 0, 4, 0, 1);
      for (int i = 0; i < 66; i++) begin
         run_period(i == 0, 1, 1, 3, 'h0400, 1);
         check("saw_ramp", int'(sample), 96 + (i % 64));
      end

      // Triangle on ch2 over a full period.
      run_period(1, 1, 1, 4, 0, 1);
      for (int i = 0; i < 66; i++) run_period(i == 0, 1, 2, 1, 'h0400, 1);

      // Collisions with ch1's own slot: clear wins, then plain rewrite advancing by the old increment.
      run_period(1, 1, 1, 3, 'h0800, 0);
      run_period(0, 0, 0, 0, 0, 0);
      run_period(1, DIV - CHANNELS + 1, 1, 2, 'h1000, 1);
      run_period(0, 0, 0, 0, 0, 0);
      run_period(1, DIV - CHANNELS + 1, 1, 3, 'h2000, 0);
      run_period(1, DIV - CHANNELS, 1, 1, 'h0300, 1);
      run_period(0, 0, 0, 0, 0, 0);

      // Random configuration traffic, biased toward the RUN window.
      for (int i = 0; i < 60; i++) begin
         int w;
         w = ($urandom_range(0, 1) == 1) ? int'($urandom_range(DIV - CHANNELS - 2, DIV))
                                          : int'($urandom_range(1, DIV));
         run_period($urandom_range(0, 3) != 0, w, int'($urandom_range(0, CHANNELS - 1)),
                    int'($urandom_range(0, 7)),
                    ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 'h0FFF)) : int'($urandom_range(0, 'hFFFF)),
                    1'($urandom_range(0, 1)));
      end

      // Make the mix audibly non-idle, then abort a pass mid-RUN with reset.
      run_period(1, 1, 0, 2, 0, 1);
      for (int i = 1; i <= DIV - CHANNELS + 1; i++) begin
         step();
         cfg_we        = 1'b0;
         cfg_phase_clr = 1'b0;
      end
      apply_reset();
      check("post_reset_mix", int'(sample), 128);
      run_period(0, 0, 0, 0, 0, 0);
      check("post_reset_mix", int'(sample), 128);

`ifdef MULTI_AUDIO_WAVE_SINE_EN
      peak = 0;
      for (int i = 0; i < 70; i++) begin
         run_period(i == 0, 1, 3, 0, 'h0100, 1);
         if (int'(sample) > peak) peak = int'(sample);
      end
      check("sine_peak", peak, 96 + 63);
`else
      peak = 0;
      for (int i = 0; i < 3; i++) begin
         run_period(i == 0, 1, 3, 0, 'h0100, 1);
         if (int'(sample) > peak) peak = int'(sample);
      end
      check("sin_disabled_mid", peak, 128);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
